// File: rtl/tage_update_queue.sv
// tage_update_queue: buffers resolved branches from commit and replays them one per cycle as TAGE training requests.
package config_pkg;
  typedef struct packed {
    int unsigned PLEN;
  } cfg_t;
  localparam cfg_t EmptyCfg = '{PLEN: 32};
endpackage

module tage_update_queue #(
  parameter config_pkg::cfg_t Cfg = config_pkg::EmptyCfg,
  parameter int COMMIT_W = 2,
  parameter int DEPTH = 8,
  parameter int GHR_BITS = 8,
  localparam int PLEN = int'(Cfg.PLEN),
  localparam int GHR_W = GHR_BITS > 1 ? GHR_BITS : 1,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [COMMIT_W-1:0]       enq_valid_i,
  input  logic [COMMIT_W*PLEN-1:0]  enq_pc_i,
  input  logic [COMMIT_W*GHR_W-1:0] enq_ghr_i,
  input  logic [COMMIT_W-1:0]       enq_taken_i,
  output logic                      enq_ready_o,
  input  logic                      update_hold_i,
  output logic                      update_valid_o,
  output logic [PLEN-1:0]           update_pc_o,
  output logic [GHR_W-1:0]          update_ghr_o,
  output logic                      update_taken_o,
  output logic [CW-1:0]             count_o
);
  logic [PLEN-1:0] pc_q [DEPTH];
  logic [GHR_W-1:0] ghr_q [DEPTH];
  logic [DEPTH-1:0] taken_q;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, n_enq;
  logic [AW-1:0] slot [COMMIT_W];
  logic pop;
  assign enq_ready_o = count <= CW'(DEPTH - COMMIT_W);
  assign pop = (count != '0) && !update_hold_i;
  assign update_valid_o = pop;
  assign update_pc_o = pop ? pc_q[rd_ptr] : '0;
  assign update_ghr_o = pop ? ghr_q[rd_ptr] : '0;
  assign update_taken_o = pop ? taken_q[rd_ptr] : 1'b0;
  assign count_o = count;
  // Each accepted lane lands after the accepted lanes below it, compacting gaps.
  always_comb begin
    n_enq = '0;
    for (int i = 0; i < COMMIT_W; i++) begin
      slot[i] = wr_ptr + n_enq[AW-1:0];
      n_enq = n_enq + CW'(enq_valid_i[i] & enq_ready_o);
    end
  end
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < COMMIT_W; i++) begin
      if (enq_ready_o && enq_valid_i[i]) begin
        pc_q[slot[i]] <= enq_pc_i[i*PLEN +: PLEN];
        ghr_q[slot[i]] <= enq_ghr_i[i*GHR_W +: GHR_W];
        taken_q[slot[i]] <= enq_taken_i[i];
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      rd_ptr <= rd_ptr + AW'(pop);
      wr_ptr <= wr_ptr + n_enq[AW-1:0];
      count <= count + n_enq - CW'(pop);
    end
  end
endmodule

// File: tb/tb_tage_update_queue.sv
// tb_tage_update_queue: directed stimulus checked against a queue-based model of the update buffer.
module tb_tage_update_queue;
  localparam int CWD = 2;
  localparam int DEP = 8;
  typedef struct {
    logic [31:0] pc;
    logic [7:0] ghr;
    logic t;
  } ent_t;
  logic clk = 0;
  logic rst_n = 0;
  logic [1:0] vld = 0;
  logic [63:0] pcs = 0;
  logic [15:0] ghrs = 0;
  logic [1:0] tkn = 0;
  logic hold = 0;
  logic rdy, uv, ut;
  logic [31:0] upc;
  logic [7:0] ughr;
  logic [3:0] cnt;
  int checks = 0;
  int errors = 0;
  ent_t q[$];

  tage_update_queue #(.COMMIT_W(CWD), .DEPTH(DEP), .GHR_BITS(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .enq_valid_i(vld), .enq_pc_i(pcs),
    .enq_ghr_i(ghrs), .enq_taken_i(tkn), .enq_ready_o(rdy),
    .update_hold_i(hold), .update_valid_o(uv), .update_pc_o(upc),
    .update_ghr_o(ughr), .update_taken_o(ut), .count_o(cnt)
  );

  always #5 clk = ~clk;

  // Model: a plain FIFO of entries; head leaves when nonempty and not held, group enters when room for a full group.
  always @(posedge clk) begin
    if (!rst_n) q.delete();
    else begin
      automatic bit room = q.size() <= DEP - CWD;
      if (q.size() != 0 && !hold) void'(q.pop_front());
      if (room)
        for (int i = 0; i < CWD; i++)
          if (vld[i]) q.push_back('{pcs[i*32 +: 32], ghrs[i*8 +: 8], tkn[i]});
    end
  end

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  task automatic cmp();
    automatic bit ev = q.size() != 0 && !hold;
    chk("valid", 32'(uv), 32'(ev));
    chk("count", 32'(cnt), q.size());
    chk("ready", 32'(rdy), 32'(q.size() <= DEP - CWD));
    chk("pc", upc, ev ? q[0].pc : 32'h0);
    chk("ghr", 32'(ughr), ev ? 32'(q[0].ghr) : 32'h0);
    chk("taken", 32'(ut), ev ? 32'(q[0].t) : 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cmp();
  endtask

  task automatic lane(int l, logic [31:0] pc, logic t);
    vld[l] = 1;
    pcs[l*32 +: 32] = pc;
    ghrs[l*8 +: 8] = pc[7:0] ^ 8'h3c;
    tkn[l] = t;
  endtask

  task automatic lit(string n, logic v, logic [3:0] c, logic [31:0] pc);
    chk({n, "_valid"}, 32'(uv), 32'(v));
    chk({n, "_count"}, 32'(cnt), 32'(c));
    if (v) chk({n, "_pc"}, upc, pc);
  endtask

  initial begin
    tick();
    tick();
    chk("rst_ready", 32'(rdy), 32'h1);
    lit("rst", 0, 0, 0);
    rst_n = 1;
    tick();
    lane(0, 32'h8000_0010, 1);
    ghrs[7:0] = 8'ha5;
    tick();
    vld = 0;
    lit("single", 1, 1, 32'h8000_0010);
    chk("single_ghr", 32'(ughr), 32'ha5);
    chk("single_taken", 32'(ut), 32'h1);
    tick();
    lit("single_after", 0, 0, 0);
    lane(0, 32'h100, 0);
    lane(1, 32'h104, 1);
    tick();
    vld = 0;
    lane(1, 32'h200, 1);
    lit("dual0", 1, 2, 32'h100);
    tick();
    vld = 0;
    lit("dual1", 1, 2, 32'h104);
    tick();
    lit("dual2", 1, 1, 32'h200);
    tick();
    lit("dual3", 0, 0, 0);
    hold = 1;
    for (int g = 0; g < 4; g++) begin
      lane(0, 32'h3000 + 32'(16 * g), g[0]);
      lane(1, 32'h3008 + 32'(16 * g), !g[0]);
      tick();
    end
    chk("bp_full_ready", 32'(rdy), 32'h0);
    lane(0, 32'hdead_0000, 1);
    lane(1, 32'hdead_0004, 1);
    tick();
    vld = 0;
    lit("bp_reject", 0, 8, 0);
    hold = 0;
    tick();
    lit("bp_drain0", 1, 7, 32'h3008);
    for (int i = 0; i < 7; i++) tick();
    lit("bp_drained", 0, 0, 0);
    hold = 1;
    lane(0, 32'h400, 1);
    lane(1, 32'h404, 0);
    tick();
    vld = 0;
    lane(0, 32'h408, 1);
    tick();
    vld = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      lit("hold", 0, 3, 0);
    end
    hold = 0;
    tick();
    lit("hold_rel0", 1, 2, 32'h404);
    tick();
    tick();
    lit("hold_rel2", 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      vld = 0;
      lane(0, 32'h1000 + 32'(4 * i), i[1]);
      tick();
      lit("wrap", 1, 1, 32'h1000 + 32'(4 * i));
    end
    vld = 0;
    tick();
    lit("wrap_end", 0, 0, 0);
    hold = 1;
    lane(0, 32'h500, 0);
    lane(1, 32'h504, 1);
    tick();
    tick();
    vld = 0;
    lane(0, 32'h508, 0);
    tick();
    vld = 0;
    lit("mid_fill", 0, 5, 0);
    hold = 0;
    rst_n = 0;
    tick();
    rst_n = 1;
    lit("mid_rst", 0, 0, 0);
    chk("mid_rst_ready", 32'(rdy), 32'h1);
    for (int i = 0; i < 4; i++) tick();
    lit("mid_rst_after", 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
